// File: rtl/mel_accum_bank.sv
// Mel filterbank accumulator: weighted FFT power bins are split between two
// adjacent triangular filters and summed into saturating channel energies.
module mel_accum_bank #(
  parameter int N_FILT = 24,
  parameter int IN_W   = 41,
  parameter int WT_W   = 8,
  parameter int ACC_W  = 46,
  parameter int IDX_W  = $clog2(N_FILT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_pow,
  input  logic [WT_W-1:0]  in_wt,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [IDX_W-1:0] out_ch,
  output logic             out_last,
  output logic             out_sat,
  output logic             err_nofirst
);

  localparam int PROD_W = IN_W + WT_W;
  // Products may be wider than the accumulator, so sums are formed one bit
  // wider than the larger operand before clamping.
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_FILT - 1);
  localparam logic [WT_W:0]    WT_ONE  = {1'b1, {WT_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  state_t           state, state_nxt;
  logic             take;
  logic             err_nxt;
  logic [IDX_W-1:0] ch;

  logic              vld_p1;
  logic              first_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [PROD_W-1:0] hi_p1;
  logic [PROD_W-1:0] lo_p1;

  logic [ACC_W-1:0] acc     [N_FILT];
  logic [ACC_W-1:0] acc_nxt [N_FILT];
  logic             sat;
  logic             sat_hit;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   r_hi;
  logic [ACC_W:0]   r_lo;

  // Returns {overflow, clamped sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                             input logic [PROD_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(ACC_MAX)) return {1'b1, ACC_MAX};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    take      = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_first) begin
            take      = 1'b1;
            state_nxt = in_last ? FLUSH : ACCUM;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          take = 1'b1;
          if (in_last) state_nxt = FLUSH;
        end
      end
      FLUSH: state_nxt = DRAIN;
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (ch == LAST_CH)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ch          <= '0;
      err_nofirst <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_nofirst <= err_nxt;
      if ((state == DRAIN) && out_ready)
        ch <= (ch == LAST_CH) ? '0 : ch + 1'b1;
    end
  end

  // Stage 1: register target index and both full-precision products.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
    end else begin
      vld_p1   <= take;
      first_p1 <= in_first;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      idx_p1 <= in_idx;
      hi_p1  <= PROD_W'(in_pow) * PROD_W'(in_wt);
      lo_p1  <= PROD_W'(in_pow) * PROD_W'(WT_ONE - {1'b0, in_wt});
    end
  end

  // Stage 2: hi lands on channel k, lo on channel k-1; out-of-range targets
  // simply match no channel. A first beat replaces the old sums.
  always_comb begin
    sat_hit = 1'b0;
    base    = '0;
    r_hi    = '0;
    r_lo    = '0;
    for (int i = 0; i < N_FILT; i++) begin
      base       = first_p1 ? '0 : acc[i];
      r_hi       = sat_add(base, (idx_p1 == IDX_W'(i)) ? hi_p1 : '0);
      r_lo       = sat_add(r_hi[ACC_W-1:0], (idx_p1 == IDX_W'(i + 1)) ? lo_p1 : '0);
      acc_nxt[i] = r_lo[ACC_W-1:0];
      sat_hit    = sat_hit | r_hi[ACC_W] | r_lo[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_FILT; i++) acc[i] <= '0;
      sat <= 1'b0;
    end else if (vld_p1) begin
      for (int i = 0; i < N_FILT; i++) acc[i] <= acc_nxt[i];
      sat <= (first_p1 ? 1'b0 : sat) | sat_hit;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_FILT; i++)
      if (out_valid && (ch == IDX_W'(i))) out_data = acc[i];
  end

  assign out_ch   = ch;
  assign out_last = out_valid && (ch == LAST_CH);
  assign out_sat  = out_valid && sat;

endmodule

// File: tb/tb_mel_accum_bank.sv
// Bench for mel_accum_bank: directed and random frames checked against a
// plain-arithmetic filterbank model.
module tb_mel_accum_bank;
  localparam int N_FILT = 4;
  localparam int IN_W   = 8;
  localparam int WT_W   = 4;
  localparam int ACC_W  = 16;
  localparam int IDX_W  = 3;
  localparam longint ACC_MAX = 65535;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_pow;
  logic [WT_W-1:0]  in_wt;
  logic [IDX_W-1:0] in_idx;
  logic             in_first;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [IDX_W-1:0] out_ch;
  logic             out_last;
  logic             out_sat;
  logic             err_nofirst;

  mel_accum_bank #(.N_FILT(N_FILT), .IN_W(IN_W), .WT_W(WT_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pow(in_pow), .in_wt(in_wt), .in_idx(in_idx), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_sat(out_sat), .err_nofirst(err_nofirst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint model_acc [N_FILT];
  bit     model_sat;
  bit     model_open;

  longint obs_data [N_FILT];
  int     obs_ch   [N_FILT];
  bit     obs_last [N_FILT];
  bit     obs_sat  [N_FILT];
  int     obs_n, obs_wait;
  bit     obs_inrdy_ok, obs_stable_ok, obs_post_valid;

  task automatic model_add(input int c, input longint v);
    model_acc[c] += v;
    if (model_acc[c] > ACC_MAX) begin
      model_acc[c] = ACC_MAX;
      model_sat    = 1'b1;
    end
  endtask

  task automatic model_beat(input int p, input int w, input int k, input bit fst, input bit lst);
    if (fst) begin
      for (int i = 0; i < N_FILT; i++) model_acc[i] = 0;
      model_sat  = 1'b0;
      model_open = 1'b1;
    end else if (!model_open) begin
      return;
    end
    if (k < N_FILT) model_add(k, longint'(p) * w);
    if (k >= 1 && k <= N_FILT) model_add(k - 1, longint'(p) * ((1 << WT_W) - w));
    if (lst) model_open = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_FILT; i++) model_acc[i] = 0;
    model_sat  = 1'b0;
    model_open = 1'b0;
  endtask

  task automatic send_beat(input int p, input int w, input int k, input bit fst, input bit lst);
    @(negedge clk);
    in_valid = 1'b1;
    in_pow   = IN_W'(p);
    in_wt    = WT_W'(w);
    in_idx   = IDX_W'(k);
    in_first = fst;
    in_last  = lst;
    model_beat(p, w, k, fst, lst);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Collects one full drain; optional stall of stall_n cycles on stall_ch.
  task automatic run_drain(input int stall_ch, input int stall_n);
    obs_wait = 0; obs_n = 0;
    obs_inrdy_ok = 1'b1; obs_stable_ok = 1'b1; obs_post_valid = 1'b0;
    for (int i = 0; i < N_FILT; i++) begin
      obs_data[i] = -1; obs_ch[i] = -1; obs_last[i] = 1'b0; obs_sat[i] = 1'b0;
    end
    do begin
      @(negedge clk);
      obs_wait++;
    end while (!out_valid && obs_wait < 20);
    if (!out_valid) return;
    for (int i = 0; i < N_FILT; i++) begin
      if (i > 0) @(negedge clk);
      if (!out_valid) break;
      obs_data[i] = out_data; obs_ch[i] = out_ch;
      obs_last[i] = out_last; obs_sat[i] = out_sat;
      obs_n++;
      if (in_ready) obs_inrdy_ok = 1'b0;
      if (i == stall_ch && stall_n > 0) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          if (!out_valid || out_data !== ACC_W'(obs_data[i]) || out_ch !== IDX_W'(obs_ch[i])
              || out_last !== obs_last[i]) obs_stable_ok = 1'b0;
          if (in_ready) obs_inrdy_ok = 1'b0;
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    obs_post_valid = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_pow = '0; in_wt = '0; in_idx = '0;
    in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0d want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
    n_checks++; if ({out_data, out_ch, out_last, out_sat, err_nofirst} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got data=%0d ch=%0d last=%0d sat=%0d err=%0d want all 0",
                         out_data, out_ch, out_last, out_sat, err_nofirst); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got in_ready=%0d out_valid=%0d want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_basic();
    longint exp_v [N_FILT] = '{128, 320, 64, 0};
    send_beat(16, 8, 1, 1'b1, 1'b0);
    send_beat(16, 4, 2, 1'b0, 1'b1);
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_flush: got in_ready=%0d out_valid=%0d want 0/0", in_ready, out_valid); end
    run_drain(-1, 0);
    n_checks++; if (obs_wait !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d negedges want 2", obs_wait); end
    n_checks++; if (obs_n !== N_FILT) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", obs_n, N_FILT); end
    for (int i = 0; i < N_FILT; i++) begin
      n_checks++;
      if (obs_data[i] !== exp_v[i] || obs_ch[i] !== i || obs_last[i] !== (i == N_FILT - 1)) begin
        n_fail++; $display("FAIL basic_ch%0d: got data=%0d ch=%0d last=%0d want data=%0d ch=%0d last=%0d",
                           i, obs_data[i], obs_ch[i], obs_last[i], exp_v[i], i, (i == N_FILT - 1)); end
    end
    n_checks++; if (obs_sat[N_FILT-1] !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %0d want 0", obs_sat[N_FILT-1]); end
    n_checks++; if (obs_inrdy_ok !== 1'b1 || obs_post_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain_end: got inrdy_ok=%0d post_valid=%0d want 1/0", obs_inrdy_ok, obs_post_valid); end
  endtask

  task automatic test_edges();
    longint exp_v [N_FILT] = '{50, 0, 0, 110};
    send_beat(10, 5, 0, 1'b1, 1'b0);
    send_beat(10, 5, 4, 1'b0, 1'b0);
    send_beat(200, 3, 7, 1'b0, 1'b1);
    run_drain(-1, 0);
    n_checks++; if (obs_n !== N_FILT) begin n_fail++; $display("FAIL edges_count: got %0d want %0d", obs_n, N_FILT); end
    for (int i = 0; i < N_FILT; i++) begin
      n_checks++;
      if (obs_data[i] !== exp_v[i] || obs_data[i] !== model_acc[i]) begin
        n_fail++; $display("FAIL edges_ch%0d: got %0d want %0d", i, obs_data[i], exp_v[i]); end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 18; i++) send_beat(255, 15, 1, i == 0, i == 17);
    run_drain(-1, 0);
    n_checks++; if (obs_data[1] !== 65535) begin n_fail++; $display("FAIL sat_ch1: got %0d want 65535", obs_data[1]); end
    n_checks++; if (obs_data[0] !== 4590) begin n_fail++; $display("FAIL sat_ch0: got %0d want 4590", obs_data[0]); end
    n_checks++; if (obs_data[2] !== 0 || obs_data[3] !== 0) begin
      n_fail++; $display("FAIL sat_ch23: got %0d/%0d want 0/0", obs_data[2], obs_data[3]); end
    n_checks++; if (obs_sat[N_FILT-1] !== 1'b1 || obs_last[N_FILT-1] !== 1'b1) begin
      n_fail++; $display("FAIL sat_flag: got sat=%0d last=%0d want 1/1", obs_sat[N_FILT-1], obs_last[N_FILT-1]); end
    send_beat(1, 1, 1, 1'b1, 1'b1);
    run_drain(-1, 0);
    n_checks++; if (obs_sat[N_FILT-1] !== 1'b0) begin n_fail++; $display("FAIL sat_clean: got %0d want 0", obs_sat[N_FILT-1]); end
    n_checks++; if (obs_data[0] !== 15 || obs_data[1] !== 1) begin
      n_fail++; $display("FAIL single_bin: got ch0=%0d ch1=%0d want 15/1", obs_data[0], obs_data[1]); end
  endtask

  task automatic test_backpressure();
    send_beat(200, 9, 2, 1'b1, 1'b0);
    send_beat(37, 14, 3, 1'b0, 1'b0);
    send_beat(91, 0, 1, 1'b0, 1'b1);
    run_drain(2, 3);
    n_checks++; if (obs_stable_ok !== 1'b1) begin n_fail++; $display("FAIL bp_stable: got %0d want 1", obs_stable_ok); end
    n_checks++; if (obs_inrdy_ok !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready: got %0d want 1", obs_inrdy_ok); end
    n_checks++; if (obs_n !== N_FILT || obs_post_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_count: got n=%0d post_valid=%0d want %0d/0", obs_n, obs_post_valid, N_FILT); end
    for (int i = 0; i < N_FILT; i++) begin
      n_checks++;
      if (obs_ch[i] !== i || obs_data[i] !== model_acc[i]) begin
        n_fail++; $display("FAIL bp_ch%0d: got ch=%0d data=%0d want ch=%0d data=%0d", i, obs_ch[i], obs_data[i], i, model_acc[i]); end
    end
  endtask

  task automatic test_protocol();
    send_beat(100, 7, 2, 1'b0, 1'b0);
    n_checks++; if (err_nofirst !== 1'b1) begin n_fail++; $display("FAIL nofirst_pulse: got %0d want 1", err_nofirst); end
    for (int i = 0; i < N_FILT; i++) begin
      n_checks++;
      if (dut.acc[i] !== ACC_W'(model_acc[i])) begin
        n_fail++; $display("FAIL nofirst_acc%0d: got %0d want %0d", i, dut.acc[i], model_acc[i]); end
    end
    @(posedge clk); #1;
    n_checks++; if (err_nofirst !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL nofirst_end: got err=%0d in_ready=%0d want 0/1", err_nofirst, in_ready); end
    send_beat(50, 3, 1, 1'b1, 1'b0);
    send_beat(60, 9, 2, 1'b0, 1'b0);
    send_beat(70, 2, 3, 1'b1, 1'b0);
    send_beat(80, 11, 1, 1'b0, 1'b1);
    run_drain(-1, 0);
    for (int i = 0; i < N_FILT; i++) begin
      n_checks++;
      if (obs_data[i] !== model_acc[i]) begin
        n_fail++; $display("FAIL restart_ch%0d: got %0d want %0d", i, obs_data[i], model_acc[i]); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++)
        send_beat($urandom_range(0, 255), $urandom_range(0, 15), $urandom_range(0, 6), b == 0, b == len - 1);
      run_drain($urandom_range(0, N_FILT - 1), $urandom_range(0, 2));
      n_checks++; if (obs_n !== N_FILT || obs_stable_ok !== 1'b1) begin
        n_fail++; $display("FAIL rand%0d_drain: got n=%0d stable=%0d want %0d/1", f, obs_n, obs_stable_ok, N_FILT); end
      for (int i = 0; i < N_FILT; i++) begin
        n_checks++;
        if (obs_data[i] !== model_acc[i] || obs_ch[i] !== i) begin
          n_fail++; $display("FAIL rand%0d_ch%0d: got %0d want %0d", f, i, obs_data[i], model_acc[i]); end
      end
      n_checks++; if (obs_sat[N_FILT-1] !== model_sat) begin
        n_fail++; $display("FAIL rand%0d_sat: got %0d want %0d", f, obs_sat[N_FILT-1], model_sat); end
    end
  endtask

  task automatic test_reset_mid_drain();
    int waited;
    send_beat(16, 8, 1, 1'b1, 1'b0);
    send_beat(16, 4, 2, 1'b0, 1'b1);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid && waited < 20);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_drain_start: got %0d want 1", out_valid); end
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_ch !== 1) begin n_fail++; $display("FAIL rst_at_ch1: got %0d want 1", out_ch); end
    #2 reset = 1'b0;
    #1;
    model_clear();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_ch !== 0 || out_data !== 0 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: got valid=%0d in_ready=%0d ch=%0d data=%0d last=%0d want 0/1/0/0/0",
                         out_valid, in_ready, out_ch, out_data, out_last); end
    for (int i = 0; i < N_FILT; i++) begin
      n_checks++;
      if (dut.acc[i] !== ACC_W'(model_acc[i])) begin
        n_fail++; $display("FAIL rst_acc%0d: got %0d want 0", i, dut.acc[i]); end
    end
    @(negedge clk);
    reset = 1'b1;
    send_beat(5, 5, 1, 1'b0, 1'b0);
    n_checks++; if (err_nofirst !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got err=%0d want 1", err_nofirst); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_saturation();
    test_backpressure();
    test_protocol();
    test_random();
    test_reset_mid_drain();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

endmodule
